axis_pattern_checker: RTL and testbench

AXIS_PATTERN_CHECKER -- requirements
Module: axis_pattern_checker

---
 rtl/axis_pattern_checker.sv | 202 ++++++++++++++++++++
 tb/tb_axis_pattern_checker.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_pattern_checker.sv
// -----------------------------------------------------------------------------
// axis_pattern_checker
//
// AXI4-Stream sink that checks incoming packets against an incrementing data
// pattern (beat i of every packet must carry seed + i) and a fixed packet
// length. It applies a programmable, rotating backpressure pattern on
// s_tready and keeps packet/error counters plus sticky error flags.
//
// Ports
//   clk, reset            : clock, asynchronous active-high reset
//   s_tvalid/s_tready     : stream handshake (s_tready is registered)
//   s_tdata/s_tkeep/s_tlast : stream payload
//   enable                : accept packets while high
//   exp_len               : expected beats per packet (0 treated as 1)
//   seed                  : expected tdata of beat 0
//   ready_pattern         : backpressure rotation pattern (0 = always ready)
//   clear                 : pulse, zeroes counters, flags, first_err_beat
//   busy                  : state is not IDLE
//   pkt_count/err_count   : saturating packet / errored-packet counters
//   err_flags             : sticky {long, short, keep, data}
//   first_err_beat        : beat index of first data/keep error
// -----------------------------------------------------------------------------
module axis_pattern_checker #(
    parameter  int WIDTH      = 32,
    parameter  int LEN_WIDTH  = 16,
    parameter  int CNT_WIDTH  = 32,
    localparam int BYTE_WIDTH = WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  s_tvalid,
    output logic                  s_tready,
    input  logic [WIDTH-1:0]      s_tdata,
    input  logic [BYTE_WIDTH-1:0] s_tkeep,
    input  logic                  s_tlast,
    input  logic                  enable,
    input  logic [LEN_WIDTH-1:0]  exp_len,
    input  logic [WIDTH-1:0]      seed,
    input  logic [31:0]           ready_pattern,
    input  logic                  clear,
    output logic                  busy,
    output logic [CNT_WIDTH-1:0]  pkt_count,
    output logic [CNT_WIDTH-1:0]  err_count,
    output logic [3:0]            err_flags,
    output logic [LEN_WIDTH-1:0]  first_err_beat
);

    typedef enum logic [1:0] {
        IDLE,
        RECV,
        DRAIN
    } state_t;

    state_t                 state_q, state_d;
    logic [31:0]            mask_q, mask_d;
    logic                   ready_q, ready_d;
    logic                   busy_q, busy_d;
    logic [LEN_WIDTH-1:0]   idx_q, idx_d;
    logic                   pkt_err_q, pkt_err_d;
    logic [CNT_WIDTH-1:0]   pkt_count_q, pkt_count_d;
    logic [CNT_WIDTH-1:0]   err_count_q, err_count_d;
    logic [3:0]             err_flags_q, err_flags_d;
    logic [LEN_WIDTH-1:0]   feb_q, feb_d;

    logic                   accept;
    logic [LEN_WIDTH-1:0]   exp_last;
    logic [LEN_WIDTH-1:0]   idx_inc;
    logic [WIDTH-1:0]       exp_data;
    logic                   data_err;
    logic                   keep_err;
    logic                   short_err;
    logic                   long_err;
    logic                   end_pkt;

    assign accept   = s_tvalid & ready_q;
    assign exp_last = (exp_len == '0) ? '0 : exp_len - LEN_WIDTH'(1);
    assign idx_inc  = (idx_q == '1) ? idx_q : idx_q + LEN_WIDTH'(1);
    assign exp_data = seed + WIDTH'(idx_q);

    // Data/keep are only checked while in RECV; DRAIN swallows the excess
    // beats of an over-long packet without further checking.
    assign data_err = accept && (state_q == RECV) && (s_tdata != exp_data);
    assign keep_err = accept && (state_q == RECV) && (s_tkeep != '1);

    always_comb begin
        state_d     = state_q;
        mask_d      = mask_q;
        idx_d       = idx_q;
        pkt_err_d   = pkt_err_q;
        pkt_count_d = pkt_count_q;
        err_count_d = err_count_q;
        err_flags_d = err_flags_q;
        feb_d       = feb_q;
        short_err   = 1'b0;
        long_err    = 1'b0;
        end_pkt     = 1'b0;

        case (state_q)
            IDLE: begin
                if (enable) begin
                    state_d = RECV;
                    mask_d  = (ready_pattern == '0) ? '1 : ready_pattern;
                end
            end
            RECV: begin
                mask_d = {mask_q[0], mask_q[31:1]};
                if (accept) begin
                    if (s_tlast) begin
                        short_err = (idx_q < exp_last);
                        end_pkt   = 1'b1;
                    end else if (idx_q == exp_last) begin
                        long_err = 1'b1;
                        state_d  = DRAIN;
                        idx_d    = idx_inc;
                    end else begin
                        idx_d = idx_inc;
                    end
                end else if (!enable && (idx_q == '0)) begin
                    // No packet in progress: leave immediately.
                    state_d = IDLE;
                end
            end
            DRAIN: begin
                mask_d = {mask_q[0], mask_q[31:1]};
                if (accept) begin
                    if (s_tlast) begin
                        end_pkt = 1'b1;
                    end else begin
                        idx_d = idx_inc;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (end_pkt) begin
            idx_d       = '0;
            pkt_err_d   = 1'b0;
            state_d     = enable ? RECV : IDLE;
            pkt_count_d = (pkt_count_q == '1) ? pkt_count_q
                                              : pkt_count_q + CNT_WIDTH'(1);
            if (pkt_err_q || data_err || keep_err || short_err) begin
                err_count_d = (err_count_q == '1) ? err_count_q
                                                  : err_count_q + CNT_WIDTH'(1);
            end
        end else if (data_err || keep_err || long_err) begin
            pkt_err_d = 1'b1;
        end

        err_flags_d = err_flags_q | {long_err, short_err, keep_err, data_err};
        if ((data_err || keep_err) && (err_flags_q[1:0] == 2'b00)) begin
            feb_d = idx_q;
        end

        // Clear wins over any same-cycle update but leaves the datapath alone.
        if (clear) begin
            pkt_count_d = '0;
            err_count_d = '0;
            err_flags_d = '0;
            feb_d       = '0;
        end

        ready_d = (state_d != IDLE) && mask_d[0];
        busy_d  = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            mask_q      <= '1;
            ready_q     <= 1'b0;
            busy_q      <= 1'b0;
            idx_q       <= '0;
            pkt_err_q   <= 1'b0;
            pkt_count_q <= '0;
            err_count_q <= '0;
            err_flags_q <= '0;
            feb_q       <= '0;
        end else begin
            state_q     <= state_d;
            mask_q      <= mask_d;
            ready_q     <= ready_d;
            busy_q      <= busy_d;
            idx_q       <= idx_d;
            pkt_err_q   <= pkt_err_d;
            pkt_count_q <= pkt_count_d;
            err_count_q <= err_count_d;
            err_flags_q <= err_flags_d;
            feb_q       <= feb_d;
        end
    end

    assign s_tready       = ready_q;
    assign busy           = busy_q;
    assign pkt_count      = pkt_count_q;
    assign err_count      = err_count_q;
    assign err_flags      = err_flags_q;
    assign first_err_beat = feb_q;

endmodule

// File: tb/tb_axis_pattern_checker.sv
// -----------------------------------------------------------------------------
// tb_axis_pattern_checker
//
// Directed scenarios followed by randomized packets. Expected counters and
// flags come from a packet-level model that applies the checking rules to
// whole packets (length vs exp_len, beat i vs seed + i).
// -----------------------------------------------------------------------------
module tb_axis_pattern_checker;

    logic        clk = 1'b0;
    logic        reset;
    logic        s_tvalid;
    logic        s_tready;
    logic [31:0] s_tdata;
    logic [3:0]  s_tkeep;
    logic        s_tlast;
    logic        enable;
    logic [15:0] exp_len;
    logic [31:0] seed;
    logic [31:0] ready_pattern;
    logic        clear;
    logic        busy;
    logic [31:0] pkt_count;
    logic [31:0] err_count;
    logic [3:0]  err_flags;
    logic [15:0] first_err_beat;

    axis_pattern_checker #(
        .WIDTH     (32),
        .LEN_WIDTH (16),
        .CNT_WIDTH (32)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .s_tvalid       (s_tvalid),
        .s_tready       (s_tready),
        .s_tdata        (s_tdata),
        .s_tkeep        (s_tkeep),
        .s_tlast        (s_tlast),
        .enable         (enable),
        .exp_len        (exp_len),
        .seed           (seed),
        .ready_pattern  (ready_pattern),
        .clear          (clear),
        .busy           (busy),
        .pkt_count      (pkt_count),
        .err_count      (err_count),
        .err_flags      (err_flags),
        .first_err_beat (first_err_beat)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int unsigned total = 0;
    int unsigned bad   = 0;

    // Packet-level reference state
    int unsigned m_pkt;
    int unsigned m_err;
    logic [3:0]  m_flags;
    logic [15:0] m_feb;

    // Packet under construction
    logic [31:0] pk_data [0:15];
    logic [3:0]  pk_keep [0:15];
    int          pk_n;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic model_clear();
        m_pkt   = 0;
        m_err   = 0;
        m_flags = '0;
        m_feb   = '0;
    endtask

    // Apply the packet rules to the whole packet in pk_* arrays.
    task automatic model_pkt(input logic [31:0] sd, input int el);
        int  e;
        bit  err;
        bit  de;
        bit  ke;
        logic [31:0] want;
        e   = (el == 0) ? 0 : el - 1;
        err = 1'b0;
        for (int i = 0; i < pk_n; i++) begin
            if (i <= e) begin
                want = sd + 32'(i);
                de = (pk_data[i] != want);
                ke = (pk_keep[i] != 4'hF);
                if (de || ke) begin
                    if (m_flags[1:0] == 2'b00) m_feb = 16'(i);
                    err = 1'b1;
                end
                if (de) m_flags[0] = 1'b1;
                if (ke) m_flags[1] = 1'b1;
            end
        end
        if (pk_n - 1 < e) begin
            m_flags[2] = 1'b1;
            err = 1'b1;
        end
        if (pk_n - 1 > e) begin
            m_flags[3] = 1'b1;
            err = 1'b1;
        end
        m_pkt++;
        if (err) m_err++;
    endtask

    task automatic fill_good(input logic [31:0] sd, input int n);
        pk_n = n;
        for (int i = 0; i < n; i++) begin
            pk_data[i] = sd + 32'(i);
            pk_keep[i] = 4'hF;
        end
    endtask

    // Called just after a falling edge; returns just after the falling edge
    // following the accepting rising edge.
    task automatic send_beat(input logic [31:0] d, input logic [3:0] k, input logic l);
        int  n;
        bit  ok;
        s_tvalid = 1'b1;
        s_tdata  = d;
        s_tkeep  = k;
        s_tlast  = l;
        n = 0;
        ok = 1'b0;
        while (!ok && n < 200) begin
            ok = s_tready;
            tick();
            n++;
        end
        if (!ok) check("beat_accept_timeout", 1, 0);
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
    endtask

    task automatic send_pkt(input bit gaps);
        for (int i = 0; i < pk_n; i++) begin
            if (gaps && $urandom_range(0, 3) == 0) tick();
            send_beat(pk_data[i], pk_keep[i], (i == pk_n - 1));
        end
    endtask

    task automatic check_outs(input string tag);
        check({tag, "_pkt"},   pkt_count,      m_pkt);
        check({tag, "_err"},   err_count,      m_err);
        check({tag, "_flags"}, err_flags,      m_flags);
        check({tag, "_feb"},   first_err_beat, m_feb);
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        model_clear();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int unsigned t0;
        int          el;
        logic [31:0] sd;

        reset = 1'b1;
        s_tvalid = 1'b0;
        s_tdata = '0;
        s_tkeep = '0;
        s_tlast = 1'b0;
        enable = 1'b0;
        exp_len = 16'd4;
        seed = 32'h10;
        ready_pattern = '1;
        clear = 1'b0;
        model_clear();

        // Reset state
        repeat (2) tick();
        check("rst_tready", s_tready, 0);
        check("rst_busy", busy, 0);
        check_outs("rst");
        reset = 1'b0;
        tick();
        check("idle_tready", s_tready, 0);

        // Full-throughput packets
        enable = 1'b1;
        tick();
        check("recv_busy", busy, 1);
        check("recv_tready", s_tready, 1);
        fill_good(32'h10, 4);
        t0 = cyc;
        for (int p = 0; p < 3; p++) begin
            send_pkt(1'b0);
            model_pkt(32'h10, 4);
        end
        check("thru_cycles", cyc - t0, 12);
        check("thru_pkt3", pkt_count, 3);
        check("thru_err0", err_count, 0);
        check_outs("thru");

        // Alternating backpressure
        enable = 1'b0;
        tick();
        check("drop_busy", busy, 0);
        check("drop_tready", s_tready, 0);
        ready_pattern = 32'h5555_5555;
        enable = 1'b1;
        tick();
        for (int k = 0; k < 8; k++) begin
            check("alt_tready", s_tready, (k % 2 == 0) ? 1 : 0);
            tick();
        end
        pulse_clear();
        fill_good(32'h10, 4);
        send_pkt(1'b0);
        model_pkt(32'h10, 4);
        check("alt_pkt1", pkt_count, 1);
        check_outs("alt");

        // Data error on beat 2
        pulse_clear();
        fill_good(32'h10, 4);
        pk_data[2] = 32'hFF;
        send_pkt(1'b0);
        model_pkt(32'h10, 4);
        check("derr_flags", err_flags, 4'b0001);
        check("derr_feb", first_err_beat, 2);
        check("derr_cnt", err_count, 1);
        check_outs("derr");

        // Short then long packet
        pulse_clear();
        fill_good(32'h10, 2);
        send_pkt(1'b0);
        model_pkt(32'h10, 4);
        check("short_flags", err_flags, 4'b0100);
        fill_good(32'h10, 6);
        for (int i = 0; i < 5; i++) send_beat(pk_data[i], pk_keep[i], 1'b0);
        check("drain_busy", busy, 1);
        check("drain_flags", err_flags, 4'b1100);
        send_beat(pk_data[5], pk_keep[5], 1'b1);
        model_pkt(32'h10, 4);
        check("long_pkt", pkt_count, 2);
        check("long_err", err_count, 2);
        check_outs("long");

        // enable dropped mid-packet
        pulse_clear();
        fill_good(32'h10, 4);
        send_beat(pk_data[0], pk_keep[0], 1'b0);
        enable = 1'b0;
        send_beat(pk_data[1], pk_keep[1], 1'b0);
        send_beat(pk_data[2], pk_keep[2], 1'b0);
        check("middrop_busy", busy, 1);
        send_beat(pk_data[3], pk_keep[3], 1'b1);
        model_pkt(32'h10, 4);
        check("middrop_idle", busy, 0);
        check_outs("middrop");

        // clear coinciding with tlast of an errored packet
        ready_pattern = '1;
        enable = 1'b1;
        tick();
        fill_good(32'h10, 4);
        pk_data[1] = 32'hEE;
        for (int i = 0; i < 3; i++) send_beat(pk_data[i], pk_keep[i], 1'b0);
        check("preclr_flags", err_flags, 4'b0001);
        clear = 1'b1;
        send_beat(pk_data[3], pk_keep[3], 1'b1);
        clear = 1'b0;
        model_clear();
        check_outs("clr_tlast");

        // Reset mid-packet
        pulse_clear();
        fill_good(32'h10, 4);
        send_pkt(1'b0);
        send_beat(pk_data[0], pk_keep[0], 1'b0);
        send_beat(pk_data[1], pk_keep[1], 1'b0);
        s_tvalid = 1'b1;
        s_tdata  = pk_data[2];
        s_tkeep  = 4'hF;
        #2;
        reset = 1'b1;
        #1;
        check("mrst_tready", s_tready, 0);
        check("mrst_busy", busy, 0);
        check("mrst_pkt", pkt_count, 0);
        check("mrst_err", err_count, 0);
        check("mrst_flags", err_flags, 0);
        check("mrst_feb", first_err_beat, 0);
        tick();
        s_tvalid = 1'b0;
        reset = 1'b0;
        model_clear();
        tick();
        check("post_rst_busy", busy, 1);

        // Randomized packets
        for (int p = 0; p < 60; p++) begin
            if ($urandom_range(0, 7) == 0) pulse_clear();
            if ($urandom_range(0, 7) == 0) begin
                enable = 1'b0;
                tick();
                check("rnd_idle", busy, 0);
                case ($urandom_range(0, 2))
                    0: ready_pattern = '0;
                    1: ready_pattern = '1;
                    default: ready_pattern = $urandom;
                endcase
                enable = 1'b1;
                tick();
            end
            sd = $urandom;
            el = int'($urandom_range(0, 6));
            seed = sd;
            exp_len = 16'(el);
            pk_n = int'($urandom_range(1, 8));
            for (int i = 0; i < pk_n; i++) begin
                pk_data[i] = sd + 32'(i);
                pk_keep[i] = 4'hF;
                if ($urandom_range(0, 9) == 0) pk_data[i] = pk_data[i] ^ ($urandom | 32'h1);
                if ($urandom_range(0, 9) == 0) pk_keep[i] = 4'($urandom_range(0, 14));
            end
            send_pkt(1'b1);
            model_pkt(sd, el);
            check_outs("rnd");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
